// File: rtl/phase_sequencer_pkg.sv
// Shared encodings for the VeriRISC phase sequencer and its controller.
package phase_sequencer_pkg;

    // Instruction phases; the controller decodes these same values.
    localparam logic [2:0] INST_ADDR  = 3'd0;
    localparam logic [2:0] INST_FETCH = 3'd1;
    localparam logic [2:0] INST_LOAD  = 3'd2;
    localparam logic [2:0] IDLE       = 3'd3;
    localparam logic [2:0] OP_ADDR    = 3'd4;
    localparam logic [2:0] OP_FETCH   = 3'd5;
    localparam logic [2:0] ALU_OP     = 3'd6;
    localparam logic [2:0] STORE      = 3'd7;

    // Sequencer states.
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_PAUSED = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;
    localparam logic [1:0] ST_FAULT  = 2'd3;

    // Phases that wait for memory data and may therefore stall.
    function automatic logic is_fetch_phase(input logic [2:0] p);
        return (p == INST_FETCH) || (p == OP_FETCH);
    endfunction

endpackage

// File: rtl/phase_sequencer_sat_counter.sv
// Saturating up-counter used for the debug cycle and instruction counts.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    // Count up on inc, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/phase_sequencer.sv
// Eight-phase fetch/execute sequencer with halt, single-step, fetch
// wait-state stalling with timeout fault, and debug counters.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH = 3,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned MAX_WAIT    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   halt,
    input  logic                   run_mode,
    input  logic                   step,
    input  logic                   resume,
    input  logic                   mem_ready,
    output logic [PHASE_WIDTH-1:0] phase,
    output logic                   halted,
    output logic                   paused,
    output logic                   bus_err,
    output logic                   instr_done,
    output logic [CNT_WIDTH-1:0]   cycle_count,
    output logic [CNT_WIDTH-1:0]   instr_count
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    logic [1:0]             state_q, state_d;
    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [7:0]             wait_q,  wait_d;
    logic                   done_q,  done_d;
    logic                   cyc_inc, ins_inc;

    // Next-state logic; RUN resolves halt > timeout > stall > advance.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        wait_d  = wait_q;
        done_d  = 1'b0;
        cyc_inc = 1'b0;
        ins_inc = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_HALTED;
                    wait_d  = '0;
                end else if (is_fetch_phase(phase_q) && !mem_ready) begin
                    cyc_inc = 1'b1;
                    if (wait_q == WAIT_LAST) begin
                        state_d = ST_FAULT;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end else begin
                    cyc_inc = 1'b1;
                    wait_d  = '0;
                    phase_d = phase_q + 3'd1;
                    if (phase_q == STORE) begin
                        done_d  = 1'b1;
                        ins_inc = 1'b1;
                        if (!run_mode) begin
                            state_d = ST_PAUSED;
                        end
                    end
                end
            end
            ST_PAUSED: begin
                if (halt) begin
                    state_d = ST_HALTED;
                end else if (step || run_mode) begin
                    state_d = ST_RUN;
                    phase_d = INST_FETCH;
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    phase_d = INST_ADDR;
                    state_d = run_mode ? ST_RUN : ST_PAUSED;
                end
            end
            default: begin
                if (resume) begin
                    phase_d = INST_ADDR;
                    wait_d  = '0;
                    state_d = ST_HALTED;
                end
            end
        endcase
    end

    // State, phase and wait-state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            phase_q <= INST_ADDR;
            wait_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            wait_q  <= wait_d;
            done_q  <= done_d;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (cyc_inc),
        .count (cycle_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_instr_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ins_inc),
        .count (instr_count)
    );

    assign phase      = phase_q;
    assign halted     = (state_q == ST_HALTED);
    assign paused     = (state_q == ST_PAUSED);
    assign bus_err    = (state_q == ST_FAULT);
    assign instr_done = done_q;

endmodule

// File: tb/tb_phase_sequencer.sv
module tb_phase_sequencer;

    localparam int CNT_WIDTH = 16;
    localparam int MAX_WAIT  = 4;
    localparam longint CMAX  = (64'd1 << CNT_WIDTH) - 1;

    logic clk = 1'b0;
    logic rst, halt, run_mode, step, resume, mem_ready;
    logic [2:0]           phase;
    logic                 halted, paused, bus_err, instr_done;
    logic [CNT_WIDTH-1:0] cycle_count, instr_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    phase_sequencer #(
        .PHASE_WIDTH (3),
        .CNT_WIDTH   (CNT_WIDTH),
        .MAX_WAIT    (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .halt        (halt),
        .run_mode    (run_mode),
        .step        (step),
        .resume      (resume),
        .mem_ready   (mem_ready),
        .phase       (phase),
        .halted      (halted),
        .paused      (paused),
        .bus_err     (bus_err),
        .instr_done  (instr_done),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );

    // Behavioural model: mode as a name, counters as unbounded integers clamped.
    typedef enum int {M_RUN, M_PAUSED, M_HALTED, M_FAULT} mode_t;
    mode_t  m_mode  = M_RUN;
    int     m_phase = 0;
    int     m_stalls = 0;
    longint m_cyc = 0;
    longint m_ins = 0;
    bit     m_done = 0;

    function automatic longint clamp(input longint v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        m_done = 0;
        if (rst) begin
            m_mode = M_RUN; m_phase = 0; m_stalls = 0; m_cyc = 0; m_ins = 0;
            return;
        end
        if (m_mode == M_RUN) begin
            if (halt) begin
                m_mode = M_HALTED; m_stalls = 0;
            end else if ((m_phase % 4 == 1) && !mem_ready) begin
                m_cyc = clamp(m_cyc + 1);
                m_stalls++;
                if (m_stalls == MAX_WAIT) begin
                    m_mode = M_FAULT; m_stalls = 0;
                end
            end else begin
                m_stalls = 0;
                m_cyc = clamp(m_cyc + 1);
                m_phase = (m_phase + 1) % 8;
                if (m_phase == 0) begin
                    m_done = 1;
                    m_ins = clamp(m_ins + 1);
                    if (!run_mode) m_mode = M_PAUSED;
                end
            end
        end else if (m_mode == M_PAUSED) begin
            if (halt) m_mode = M_HALTED;
            else if (step || run_mode) begin m_mode = M_RUN; m_phase = 1; end
        end else if (m_mode == M_HALTED) begin
            if (resume) begin m_phase = 0; m_mode = run_mode ? M_RUN : M_PAUSED; end
        end else begin
            if (resume) begin m_phase = 0; m_stalls = 0; m_mode = M_HALTED; end
        end
    endtask

    // Advance the model on each edge and compare every output shortly after.
    always begin
        @(posedge clk);
        model_step();
        #1;
        chk("phase",       phase,       m_phase);
        chk("halted",      halted,      m_mode == M_HALTED);
        chk("paused",      paused,      m_mode == M_PAUSED);
        chk("bus_err",     bus_err,     m_mode == M_FAULT);
        chk("instr_done",  instr_done,  m_done);
        chk("cycle_count", cycle_count, m_cyc);
        chk("instr_count", instr_count, m_ins);
    end

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int done_seen;
        rst = 1'b1; halt = 1'b0; run_mode = 1'b1; step = 1'b0; resume = 1'b0; mem_ready = 1'b1;
        edges(2);
        chk("rst_phase", phase, 0);
        chk("rst_cycles", cycle_count, 0);
        chk("rst_flags", {halted, paused, bus_err, instr_done}, 0);
        rst = 1'b0;

        // Free run, two full instructions.
        done_seen = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (instr_done) done_seen++;
        end
        chk("t1_phase", phase, 0);
        chk("t1_cycles", cycle_count, 16);
        chk("t1_instrs", instr_count, 2);
        chk("t1_done_pulses", done_seen, 2);

        // Three wait states at INST_FETCH, then ready.
        edges(1);
        mem_ready = 1'b0;
        edges(3);
        chk("t2_stall_phase", phase, 1);
        mem_ready = 1'b1;
        edges(1);
        chk("t2_phase", phase, 2);
        chk("t2_bus_err", bus_err, 0);
        chk("t2_cycles", cycle_count, 21);

        // Timeout at OP_FETCH, then two resumes.
        edges(3);
        mem_ready = 1'b0;
        edges(4);
        chk("t3_bus_err", bus_err, 1);
        chk("t3_phase", phase, 5);
        chk("t3_cycles", cycle_count, 28);
        mem_ready = 1'b1;
        edges(2);
        resume = 1'b1;
        edges(1);
        resume = 1'b0;
        chk("t3_halted", halted, 1);
        chk("t3_phase0", phase, 0);
        chk("t3_bus_clr", bus_err, 0);
        edges(1);
        resume = 1'b1;
        edges(1);
        resume = 1'b0;
        chk("t3_running", halted, 0);

        // Halt at OP_FETCH freezes phase and counters.
        edges(5);
        halt = 1'b1;
        edges(1);
        step = 1'b1;
        edges(1);
        step = 1'b0;
        edges(9);
        chk("t4_phase", phase, 5);
        chk("t4_cycles", cycle_count, 33);
        chk("t4_halted", halted, 1);
        halt = 1'b0;
        resume = 1'b1;
        edges(1);
        resume = 1'b0;
        chk("t4_resume_phase", phase, 0);
        edges(2);
        chk("t4_phase2", phase, 2);

        // Single-step mode.
        run_mode = 1'b0;
        edges(6);
        chk("t5_paused", paused, 1);
        chk("t5_done", instr_done, 1);
        chk("t5_instrs", instr_count, 3);
        edges(5);
        chk("t5_idle_phase", phase, 0);
        chk("t5_idle_cycles", cycle_count, 41);
        step = 1'b1;
        edges(1);
        step = 1'b0;
        chk("t5_step_phase", phase, 1);
        edges(7);
        chk("t5_paused_again", paused, 1);
        chk("t5_instrs2", instr_count, 4);
        chk("t5_cycles2", cycle_count, 48);

        // Reset mid-stall.
        run_mode = 1'b1;
        edges(1);
        mem_ready = 1'b0;
        edges(2);
        chk("t6_stall_phase", phase, 1);
        rst = 1'b1;
        edges(1);
        rst = 1'b0;
        chk("t6_rst_phase", phase, 0);
        chk("t6_rst_counts", {cycle_count, instr_count}, 0);

        // Reset in FAULT.
        mem_ready = 1'b1;
        edges(1);
        mem_ready = 1'b0;
        edges(4);
        chk("t6_fault", bus_err, 1);
        rst = 1'b1;
        edges(1);
        rst = 1'b0;
        mem_ready = 1'b1;
        chk("t6_fault_rst", bus_err, 0);
        chk("t6_fault_rst_cyc", cycle_count, 0);

        // Saturation from an all-ones preload.
        force dut.u_cycle_cnt.count_q = '1;
        force dut.u_instr_cnt.count_q = '1;
        m_cyc = CMAX;
        m_ins = CMAX;
        edges(1);
        release dut.u_cycle_cnt.count_q;
        release dut.u_instr_cnt.count_q;
        edges(7);
        chk("t6_wrap_done", instr_done, 1);
        chk("t6_sat_cycles", cycle_count, CMAX);
        chk("t6_sat_instrs", instr_count, CMAX);
        edges(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
